// File: rtl/mdu.sv
// mdu: iterative radix-2 multiply/divide unit for the RV32M/RV64M EX stage.
// One multiplier or quotient bit is processed per CALC cycle on operand
// magnitudes. FIN applies the sign fix and the RISC-V special-case results.
module mdu #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [2:0]          f3_q, f3_d;
  logic [XLEN-1:0]     opa_q, opa_d;      // |a|: multiplicand, or dividend magnitude
  logic [XLEN-1:0]     opb_q, opb_d;      // |b|: divisor magnitude
  logic [2*XLEN-1:0]   acc_q, acc_d;      // {hi, lo}: product, or {remainder, quotient}
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                sa_q, sa_d;
  logic                sb_q, sb_d;
  logic                dz_q, dz_d;        // divide by zero
  logic                ovf_q, ovf_d;      // signed overflow (MIN / -1)
  logic [XLEN-1:0]     result_q, result_d;
  logic                done_q, done_d;

  // Operand decode at the accepting edge
  logic                a_signed, b_signed, a_neg, b_neg, is_div;
  logic                b_zero, div_ovf, special, accept;
  logic [XLEN-1:0]     a_mag, b_mag;
  // One iteration step of each engine
  logic [XLEN:0]       mcand_sel, mul_sum;
  logic [2*XLEN-1:0]   mul_step, div_step;
  logic [XLEN:0]       rem_sh, div_diff;
  // Final result formation
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quot_s, rem_s, a_back, fin_val;

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  // Decode signedness, magnitudes and special divides from the live operands
  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? (~a + 1'b1) : a;
    b_mag    = b_neg ? (~b + 1'b1) : b;
    is_div   = funct3[2];
    b_zero   = (b == '0);
    div_ovf  = is_div & ~funct3[0] & (a == MIN_VAL) & (b == '1);
    special  = is_div & (b_zero | div_ovf);
    accept   = (state_q == S_IDLE) & start & ~abort;
  end

  // Shift-add multiply step and restoring divide step
  always_comb begin
    mcand_sel = acc_q[0] ? {1'b0, opa_q} : {(XLEN+1){1'b0}};
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + mcand_sel;
    mul_step  = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh    = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = rem_sh - {1'b0, opb_q};
    div_step  = {(div_diff[XLEN] ? rem_sh[XLEN-1:0] : div_diff[XLEN-1:0]),
                 acc_q[XLEN-2:0], ~div_diff[XLEN]};
  end

  // Sign fix and RISC-V special-case override applied in FIN
  always_comb begin
    prod   = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
    quot_s = (sa_q ^ sb_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_s  = sa_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    a_back = sa_q ? (~opa_q + 1'b1) : opa_q;
    case (f3_q)
      3'b000:                 fin_val = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_val = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_val = dz_q ? '1 : (ovf_q ? MIN_VAL : quot_s);
      default:                fin_val = dz_q ? a_back : (ovf_q ? '0 : rem_s);
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort returns to IDLE from anywhere
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = (EARLY_OUT && special) ? S_FIN : S_CALC;
        S_CALC:  if (cnt_q == '0) state_d = S_FIN;
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs: busy decoded from registered state, done/result registered
  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = done_q;
    result = result_q;
  end

  // Datapath next values: latch on accept, iterate in CALC, write back in FIN
  always_comb begin
    f3_d     = f3_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          f3_d  = funct3;
          opa_d = a_mag;
          opb_d = b_mag;
          acc_d = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
          cnt_d = CW'(XLEN - 1);
          sa_d  = a_neg;
          sb_d  = b_neg;
          dz_d  = b_zero;
          ovf_d = div_ovf;
        end
      end
      S_CALC: begin
        if (!abort) begin
          acc_d = f3_q[2] ? div_step : mul_step;
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIN: begin
        if (!abort) begin
          result_d = fin_val;
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f3_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      f3_q     <= f3_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: vector table plus hand sequences for three mdu instances
// (XLEN=32 early-out, XLEN=32 full latency, XLEN=64 early-out).
module tb_mdu;

  logic        clock, reset;
  logic        start0, start1, start2;
  logic        abort0, abort1, abort2;
  logic [2:0]  f3_in;
  logic [63:0] a_in, b_in;
  logic        busy0, busy1, busy2, done0, done1, done2;
  logic [31:0] res0, res1;
  logic [63:0] res2;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q0[$], exp_q1[$], exp_q2[$];
  logic [63:0] last_exp0;

  mdu #(.XLEN(32), .EARLY_OUT(1'b1)) u_e32 (
    .clock(clock), .reset(reset), .start(start0), .abort(abort0), .funct3(f3_in),
    .a(a_in[31:0]), .b(b_in[31:0]), .busy(busy0), .done(done0), .result(res0));
  mdu #(.XLEN(32), .EARLY_OUT(1'b0)) u_n32 (
    .clock(clock), .reset(reset), .start(start1), .abort(abort1), .funct3(f3_in),
    .a(a_in[31:0]), .b(b_in[31:0]), .busy(busy1), .done(done1), .result(res1));
  mdu #(.XLEN(64), .EARLY_OUT(1'b1)) u_e64 (
    .clock(clock), .reset(reset), .start(start2), .abort(abort2), .funct3(f3_in),
    .a(a_in), .b(b_in), .busy(busy2), .done(done2), .result(res2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          dut;
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_busy(input int d);
    case (d)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic get_done(input int d);
    case (d)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic [63:0] get_res(input int d);
    case (d)
      0:       return {32'b0, res0};
      1:       return {32'b0, res1};
      default: return res2;
    endcase
  endfunction

  task automatic set_start(input int d, input logic v);
    case (d)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic push_exp(input int d, input logic [63:0] e);
    case (d)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic clear_exp(input int d);
    case (d)
      0:       exp_q0.delete();
      1:       exp_q1.delete();
      default: exp_q2.delete();
    endcase
  endtask

  // Scoreboard pop on each done pulse
  task automatic pop_cmp(input int d, input logic [63:0] act, input logic bsy);
    logic [63:0] e;
    logic        have;
    have = 1'b0;
    e    = '0;
    case (d)
      0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
      1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
      default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
    endcase
    check($sformatf("busy_low_with_done_dut%0d", d), {63'b0, bsy}, 64'd0);
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done_dut%0d: got result %h, required no done pulse", d, act);
    end else begin
      check($sformatf("result_dut%0d", d), act, e);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (done0) pop_cmp(0, {32'b0, res0}, busy0);
      if (done1) pop_cmp(1, {32'b0, res1}, busy1);
      if (done2) pop_cmp(2, res2, busy2);
    end
  end

  // Drive one operation, then measure done latency and busy length
  task automatic run_op(input int d, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int lat);
    int   n;
    int   busy_cnt;
    logic got;
    @(negedge clock);
    f3_in = f3;
    a_in  = a;
    b_in  = b;
    set_start(d, 1'b1);
    push_exp(d, exp);
    if (d == 0) last_exp0 = exp;
    @(posedge clock);
    #1;
    set_start(d, 1'b0);
    a_in     = {$urandom, $urandom};
    b_in     = {$urandom, $urandom};
    f3_in    = 3'($urandom);
    n        = 1;
    busy_cnt = get_busy(d) ? 1 : 0;
    got      = 1'b0;
    while (!got && n < 200) begin
      @(posedge clock);
      #1;
      n++;
      if (get_done(d)) got = 1'b1;
      else if (get_busy(d)) busy_cnt++;
    end
    $display("op dut%0d f3=%0d a=%h b=%h result=%h expected=%h edges=%0d",
             d, f3, a, b, get_res(d), exp, n);
    check($sformatf("latency_dut%0d_f3_%0d", d, f3), 64'(n), 64'(lat));
    check($sformatf("busy_cycles_dut%0d_f3_%0d", d, f3), 64'(busy_cnt), 64'(lat - 1));
    if (!got) clear_exp(d);
  endtask

  task automatic addv(input int d, input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] exp, input int lat);
    vec_t v;
    v.dut = d; v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    vt.push_back(v);
  endtask

  initial begin
    int n;
    int dn;

    reset  = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    abort0 = 1'b0; abort1 = 1'b0; abort2 = 1'b0;
    f3_in  = '0;
    a_in   = '0;
    b_in   = '0;
    last_exp0 = '0;

    // XLEN=32, EARLY_OUT=1
    addv(0, 3'b000, 64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB, 34);
    addv(0, 3'b001, 64'h80000000, 64'h80000000, 64'h40000000, 34);
    addv(0, 3'b011, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 34);
    addv(0, 3'b010, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 34);
    addv(0, 3'b001, 64'hFFFFFFFD, 64'h5,        64'hFFFFFFFF, 34);
    addv(0, 3'b011, 64'h80000000, 64'h4,        64'h2,        34);
    addv(0, 3'b100, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, 34);
    addv(0, 3'b110, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, 34);
    addv(0, 3'b101, 64'd100,      64'd7,        64'd14,       34);
    addv(0, 3'b111, 64'd100,      64'd7,        64'd2,        34);
    addv(0, 3'b100, 64'h7,        64'hFFFFFFFE, 64'hFFFFFFFD, 34);
    addv(0, 3'b110, 64'h7,        64'hFFFFFFFE, 64'h1,        34);
    addv(0, 3'b101, 64'd5,        64'd0,        64'hFFFFFFFF, 2);
    addv(0, 3'b110, 64'd5,        64'd0,        64'd5,        2);
    addv(0, 3'b100, 64'hFFFFFFF9, 64'd0,        64'hFFFFFFFF, 2);
    addv(0, 3'b110, 64'hFFFFFFF9, 64'd0,        64'hFFFFFFF9, 2);
    addv(0, 3'b100, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 2);
    addv(0, 3'b110, 64'h80000000, 64'hFFFFFFFF, 64'h0,        2);
    addv(0, 3'b101, 64'd100,      64'd7,        64'd14,       34);
    // XLEN=32, EARLY_OUT=0: same special values, full latency
    addv(1, 3'b101, 64'd5,        64'd0,        64'hFFFFFFFF, 34);
    addv(1, 3'b110, 64'd5,        64'd0,        64'd5,        34);
    addv(1, 3'b100, 64'hFFFFFFF9, 64'd0,        64'hFFFFFFFF, 34);
    addv(1, 3'b100, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 34);
    addv(1, 3'b110, 64'h80000000, 64'hFFFFFFFF, 64'h0,        34);
    // XLEN=64
    addv(2, 3'b000, 64'h7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 66);
    addv(2, 3'b011, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 66);
    addv(2, 3'b001, 64'h8000000000000000, 64'h8000000000000000, 64'h4000000000000000, 66);
    addv(2, 3'b100, 64'hFFFFFFFFFFFFFFF9, 64'h2, 64'hFFFFFFFFFFFFFFFD, 66);
    addv(2, 3'b110, 64'hFFFFFFFFFFFFFFF9, 64'h2, 64'hFFFFFFFFFFFFFFFF, 66);
    addv(2, 3'b100, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 2);
    addv(2, 3'b111, 64'd5, 64'd0, 64'd5, 2);

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("reset_busy", {61'b0, busy0, busy1, busy2}, 64'd0);
    check("reset_done", {61'b0, done0, done1, done2}, 64'd0);
    check("reset_result_32", {res0, res1}, 64'd0);
    check("reset_result_64", res2, 64'd0);
    reset = 1'b0;

    foreach (vt[i]) run_op(vt[i].dut, vt[i].f3, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat);
    @(negedge clock);

    // Abort at CALC cycle 10 of a DIV
    f3_in = 3'b100; a_in = 64'd1000; b_in = 64'd3; start0 = 1'b1;
    @(posedge clock);
    #1;
    start0 = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    check("abort_busy_before", {63'b0, busy0}, 64'd1);
    abort0 = 1'b1;
    @(posedge clock);
    #1;
    abort0 = 1'b0;
    check("abort_busy_drop", {63'b0, busy0}, 64'd0);
    dn = 0;
    repeat (40) begin @(posedge clock); #1; if (done0) dn++; end
    check("abort_no_done", 64'(dn), 64'd0);
    check("abort_result_kept", {32'b0, res0}, last_exp0);
    $display("seq abort_mid_div busy=%0d done_pulses=%0d result=%h", busy0, dn, res0);

    // start and abort together in IDLE
    @(negedge clock);
    f3_in = 3'b000; a_in = 64'd3; b_in = 64'd3; start0 = 1'b1; abort0 = 1'b1;
    @(posedge clock);
    #1;
    start0 = 1'b0; abort0 = 1'b0;
    check("start_abort_not_busy", {63'b0, busy0}, 64'd0);
    dn = 0;
    repeat (40) begin @(posedge clock); #1; if (done0) dn++; end
    check("start_abort_no_done", 64'(dn), 64'd0);
    check("start_abort_result_kept", {32'b0, res0}, last_exp0);
    $display("seq start_with_abort busy=%0d done_pulses=%0d result=%h", busy0, dn, res0);

    // Back-to-back: MUL, then DIV started in the MUL done cycle
    @(negedge clock);
    f3_in = 3'b000; a_in = 64'd6; b_in = 64'd7; start0 = 1'b1;
    exp_q0.push_back(64'd42);
    @(posedge clock);
    #1;
    start0 = 1'b0;
    n = 1;
    while (!done0 && n < 200) begin @(posedge clock); #1; n++; end
    check("b2b_first_latency", 64'(n), 64'd34);
    f3_in = 3'b100; a_in = 64'd100; b_in = 64'd7; start0 = 1'b1;
    exp_q0.push_back(64'd14);
    @(posedge clock);
    #1;
    start0 = 1'b0;
    check("b2b_no_gap_busy", {63'b0, busy0}, 64'd1);
    n = 1;
    while (!done0 && n < 200) begin @(posedge clock); #1; n++; end
    check("b2b_second_latency", 64'(n), 64'd34);
    $display("seq back_to_back second_result=%h edges=%0d", res0, n);
    if (!done0) exp_q0.delete();
    @(negedge clock);

    // Async reset in the middle of CALC
    f3_in = 3'b000; a_in = 64'd3; b_in = 64'd5; start0 = 1'b1;
    @(posedge clock);
    #1;
    start0 = 1'b0;
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_busy", {63'b0, busy0}, 64'd0);
    check("async_reset_done", {63'b0, done0}, 64'd0);
    check("async_reset_result", {32'b0, res0}, 64'd0);
    $display("seq async_reset busy=%0d done=%0d result=%h", busy0, done0, res0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
